mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
Shares one `mul_tc_16_16` signed 16x16 multiplier between NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on both sides.
- Two-stage registered pipeline: operand register, then product/output register.
- Each result is returned tagged with the requester index that issued it.
- Sits between the ALU-side clients and the shared multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must equal clog2(NREQ), checked at elaboration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_a  in  NREQ*16  packed multiplicands, requester i at [16i+15:16i], two's complement.
- req_b  in  NREQ*16  packed multipliers, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_id  out  ID_W  index of the requester that issued the result.
- out_product  out  32  signed product req_a*req_b, exact (no truncation).

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high (clk, rst).
  - While rst=1: out_valid=0, out_id=0, out_product=0, s1_valid=0, rr_ptr=0, req_ready=0 (forced combinationally).
  - Reset mid-operation discards all in-flight operations; nothing emerges after rst deasserts.
- State:
  - rr_ptr [ID_W]: round-robin pointer.
  - Stage 1: s1_valid, s1_a, s1_b, s1_id.
  - Stage 2: output registers out_valid, out_id, out_product.
- Advance conditions:
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - s1_free = !s1_valid | s2_free.
- Grant:
  - gnt = first index i with req_valid[i]=1, searching from rr_ptr upward with wrap at NREQ-1 -> 0.
  - req_ready[gnt] = s1_free & !rst; all other bits are 0.
  - req_ready depends on req_valid combinationally. Requesters must not make req_valid depend on req_ready.
- Accept: req_valid[i] & req_ready[i] at a rising edge.
  - Stage 1 loads a, b and id=i; s1_valid=1.
  - rr_ptr becomes (i+1) mod NREQ.
  - With no accept, rr_ptr holds.
- Stage 1 -> 2: on s1_adv, out_product = mul_tc_16_16(s1_a, s1_b), out_id = s1_id, out_valid=1.
  - The multiplier is purely combinational between the stage registers.
- Output handshake:
  - out_valid & out_ready & !s1_adv: out_valid drops next cycle.
  - out_product and out_id hold stable while out_valid=1 and out_ready=0.
- Latency: accept at edge N gives out_valid=1 after edge N+1, provided there is no backpressure.
- Throughput: 1 result/cycle while out_ready=1.
- Full condition: s1_valid & out_valid & !out_ready; all req_ready=0.
- Simultaneous events:
  - Output consumed, stage 1 advances and a new request is accepted, all in the same cycle: legal, no bubble.
  - A requester dropping req_valid before acceptance is legal; the grant moves that cycle.
- Arithmetic:
  - Full signed range. -32768*-32768 = 0x40000000, with no overflow.
  - Operands are never zero-extended.
- Ordering: results emerge in acceptance order; no reordering.

Decomposition:
- Package mul_share_pkg:
  - OP_W=16, PROD_W=32.
  - Function rr_pick(valid, ptr) returning index and found flag.
- Sub-module rr_arbiter (NREQ, ID_W):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any.
- The top holds the pointer, the pipeline registers and the `mul_tc_16_16` instance.

Test Plan:
- Single request, requester 2, a=-3 (0xFFFD), b=7, out_ready=1.
  - req_ready[2]=1 in the same cycle.
  - Two edges later: out_valid=1, out_id=2, out_product=0xFFFFFFEB.
- Corner operands through requester 0, out_ready=1:
  - 0x8000*0x8000 -> 0x40000000.
  - 0x7FFF*0x8000 -> 0xC0008000.
  - 0xFFFF*0xFFFF -> 0x00000001.
  - 0x0000*0x1234 -> 0.
- All 4 req_valid held high for 8 cycles, out_ready=1.
  - Acceptances in order 0,1,2,3,0,1,2,3, one per cycle.
  - out_id follows the same order, each with the correct product.
- Backpressure:
  - Setup: 3 requests accepted back-to-back, then out_ready=0 for 5 cycles.
  - Stall behaviour: out_valid stays 1 with a stable first result; s1 holds the second result; all req_ready=0.
  - Release: after out_ready returns to 1, the 2nd and 3rd results follow on consecutive cycles; nothing is lost or duplicated.
- Fairness with partial valids: req_valid=4'b1001 with rr_ptr=1 -> grant 3, then 0, then 3.
- Reset mid-operation: rst=1 for 1 cycle with s1_valid=1 and out_valid=1.
  - Next cycle: out_valid=0, out_id=0, out_product=0, rr_ptr=0.
  - No stale result appears afterwards.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mul_share_pkg;
  localparam int OP_W    = 16;
  localparam int PROD_W  = 32;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit at or above ptr, wrapping at n-1 -> 0. Walking k downward
  // leaves the closest hit to ptr as the final assignment.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0] ptr, input int n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// Round-robin grant selection; purely combinational.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [ID_W-1:0] gnt_idx_o,
  output logic            any_o
);
  pick_t              pick;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    pick                = rr_pick(req_ext, 3'(ptr_i), NREQ);
    any_o               = pick.found;
    gnt_idx_o           = ID_W'(pick.idx);
    gnt_oh_o            = '0;
    for (int i = 0; i < NREQ; i++)
      gnt_oh_o[i] = pick.found && (pick.idx == 3'(i));
  end
endmodule

// File: rtl/mul_tc_16_16.sv
// Combinational signed 16x16 multiplier with exact 32-bit product.
module mul_tc_16_16 (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/mul_share_arb.sv
// One signed 16x16 multiplier shared by NREQ requesters: round-robin grant,
// operand stage, product/output stage, results tagged with requester index.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic [PROD_W-1:0]      out_product
);
  if (ID_W != $clog2(NREQ) || NREQ < 2 || NREQ > MAX_REQ) begin : g_param_chk
    $error("mul_share_arb: NREQ must be 2..8 and ID_W must equal clog2(NREQ)");
  end

  logic [NREQ-1:0][OP_W-1:0] a_arr, b_arr;
  logic [NREQ-1:0]           gnt_oh;
  logic [ID_W-1:0]           gnt_idx;
  logic                      gnt_any;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   s1_a_q, s1_b_q;
  logic [ID_W-1:0]   s1_id_q, out_id_q;
  logic              out_valid_q, out_valid_d;
  logic [PROD_W-1:0] out_product_q;
  logic signed [PROD_W-1:0] prod;

  logic s2_free, s1_adv, s1_free, accept;

  assign a_arr = req_a;
  assign b_arr = req_b;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  mul_tc_16_16 u_mul (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (prod)
  );

  always_comb begin
    s2_free   = !out_valid_q || out_ready;
    s1_adv    = s1_valid_q && s2_free;
    s1_free   = !s1_valid_q || s2_free;
    req_ready = (gnt_any && s1_free && !rst) ? gnt_oh : '0;
    accept    = |(req_valid & req_ready);

    rr_ptr_d    = rr_ptr_q;
    if (accept)
      rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    s1_valid_d  = accept || (s1_valid_q && !s1_adv);
    out_valid_d = s1_adv || (out_valid_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_id_q       <= '0;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_product_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        s1_a_q  <= a_arr[gnt_idx];
        s1_b_q  <= b_arr[gnt_idx];
        s1_id_q <= gnt_idx;
      end
      // Output regs only move on advance so they hold under backpressure.
      if (s1_adv) begin
        out_product_q <= prod;
        out_id_q      <= s1_id_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign out_product = out_product_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: grant order, products, backpressure, reset.
module tb_mul_share_arb;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][15:0] a_v = '0;
  logic [3:0][15:0] b_v = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [1:0]       out_id;
  logic [31:0]      out_product;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_share_arb #(.NREQ(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (a_v),
    .req_b       (b_v),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_product (out_product)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
    step(); step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_id !== 2'd0 || out_product !== 32'd0) begin errors++; $display("FAIL reset_out got id=%0d p=%h exp 0/0", out_id, out_product); end
    rst = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_single();
    a_v[2] = 16'hFFFD; b_v[2] = 16'd7; req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    step(); req_valid = '0;
    step();
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_product !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL single_out got v=%b id=%0d p=%h exp 1/2/ffffffeb", out_valid, out_id, out_product); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_corners();
    logic [15:0] ca [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic [15:0] cb [4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h1234};
    logic [31:0] cp [4] = '{32'h40000000, 32'hC0008000, 32'h00000001, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      a_v[0] = ca[i]; b_v[0] = cb[i]; req_valid = 4'b0001; #1;
      step(); req_valid = '0;
      step();
      checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_product !== cp[i]) begin
        errors++; $display("FAIL corner%0d got v=%b id=%0d p=%h exp 1/0/%h", i, out_valid, out_id, out_product, cp[i]); end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] expq [8];
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        for (int i = 0; i < 4; i++) begin
          a_v[i] = 16'(k * 300 + i * 77 - 900);
          b_v[i] = 16'(-(k * 5 + i * 3 + 1));
        end
        expq[k] = smul(a_v[k % 4], b_v[k % 4]);
        req_valid = 4'b1111; #1;
        checks++; if (req_ready !== 4'(1 << (k % 4))) begin
          errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      end else req_valid = '0;
      step();
      if (k >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_id !== 2'((k - 1) % 4) || out_product !== expq[k-1]) begin
          errors++; $display("FAIL rr_out%0d got v=%b id=%0d p=%h exp id=%0d p=%h",
                             k - 1, out_valid, out_id, out_product, (k - 1) % 4, expq[k-1]); end
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] p0, p1, p2;
    a_v[0] = 16'd1234;  b_v[0] = 16'hFFF0;  p0 = 32'hFFFFB2E0;  // 1234 * -16
    a_v[1] = 16'h8001;  b_v[1] = 16'd2;     p1 = 32'hFFFF0002;  // -32767 * 2
    a_v[2] = 16'd300;   b_v[2] = 16'd300;   p2 = 32'd90000;
    out_ready = 1'b1; req_valid = 4'b0111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_g0 got=%b exp=0001", req_ready); end
    step(); req_valid = 4'b0110; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_g1 got=%b exp=0010", req_ready); end
    step(); req_valid = 4'b0100; out_ready = 1'b0; #1;
    for (int s = 0; s < 5; s++) begin
      checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd0 || out_product !== p0) begin
        errors++; $display("FAIL bp_stall%0d got rdy=%b v=%b id=%0d p=%h exp 0000/1/0/%h",
                           s, req_ready, out_valid, out_id, out_product, p0); end
      step();
    end
    out_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_g2 got=%b exp=0100", req_ready); end
    step(); req_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_product !== p1) begin
      errors++; $display("FAIL bp_r1 got v=%b id=%0d p=%h exp 1/1/%h", out_valid, out_id, out_product, p1); end
    step();
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_product !== p2) begin
      errors++; $display("FAIL bp_r2 got v=%b id=%0d p=%h exp 1/2/%h", out_valid, out_id, out_product, p2); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] expg [3] = '{4'b1000, 4'b0001, 4'b1000};
    pulse_reset();
    req_valid = 4'b0001; #1;
    step(); req_valid = '0;
    step(); step();
    req_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== expg[i]) begin errors++; $display("FAIL fair%0d got=%b exp=%b", i, req_ready, expg[i]); end
      step();
    end
    req_valid = '0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    a_v[0] = 16'd5; b_v[0] = 16'd6; a_v[1] = 16'd7; b_v[1] = 16'd8;
    out_ready = 1'b1; req_valid = 4'b0011;
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_product !== 32'd30) begin
      errors++; $display("FAIL rm_pre got v=%b p=%h exp 1/0000001e", out_valid, out_product); end
    rst = 1'b1; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready got=%b exp=0000", req_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_id !== 2'd0 || out_product !== 32'd0) begin
      errors++; $display("FAIL rm_clear got v=%b id=%0d p=%h exp 0/0/0", out_valid, out_id, out_product); end
    rst = 1'b0; req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d got=%b exp=0", i, out_valid); end
    end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
